// File: rtl/dcache_axi_req_queue_pkg.sv
// Shared types for the dcache-to-AXI request queue: the queued request record and the FSM state.
package dcache_axi_req_queue_pkg;

    localparam int unsigned ADDR_WIDTH     = 32;
    localparam int unsigned AXI_DATA_WIDTH = 32;
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef struct packed {
        logic                      we;
        logic                      uncached;
        logic [ADDR_WIDTH-1:0]     addr;
        logic [2:0]                size;
        logic [AXI_DATA_WIDTH-1:0] wdata;
        logic [AXI_STRB_WIDTH-1:0] wstrb;
    } dcache_mem_req_t;

    typedef enum logic {
        StIdle,
        StWait
    } req_state_e;

endpackage

// File: rtl/dcache_axi_req_queue_sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head.
// Pushes while full and pops while empty are ignored.
module dcache_axi_req_queue_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Push is gated on full alone: a same-cycle pop never frees a slot for a push.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/dcache_axi_req_queue.sv
// In-order request queue between the dcache and a single-beat AXI master: one request
// in flight at a time, completions returned as a registered one-cycle pulse.
module dcache_axi_req_queue
    import dcache_axi_req_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ID    = 0
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic                      req_uncached,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [2:0]                req_size,
    input  logic [AXI_DATA_WIDTH-1:0] req_wdata,
    input  logic [AXI_STRB_WIDTH-1:0] req_wstrb,

    output logic                      resp_valid,
    output logic                      resp_we,
    output logic [AXI_DATA_WIDTH-1:0] resp_data,
    output logic                      busy,

    output logic                      mst_new_request,
    output logic                      mst_we,
    output logic                      mst_uncached,
    output logic [ADDR_WIDTH-1:0]     mst_addr,
    output logic [2:0]                mst_size,
    output logic [AXI_DATA_WIDTH-1:0] mst_data_in,
    output logic [AXI_STRB_WIDTH-1:0] mst_wstrb,
    input  logic                      mst_ready,
    input  logic                      mst_rvalid,
    input  logic                      mst_wvalid,
    input  logic [AXI_DATA_WIDTH-1:0] mst_data_out
);

    // The master's AXI ID field is 16 bits wide.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ID > 32'hFFFF) begin : gen_param_err
        $error("dcache_axi_req_queue: DEPTH must be a power of two >= 2, ID must fit 16 bits");
    end

    localparam int unsigned ReqW = $bits(dcache_mem_req_t);

    dcache_mem_req_t           req_in, head;
    logic [ReqW-1:0]           head_bits;
    logic                      fifo_full, fifo_empty, fifo_pop;
    req_state_e                state_q, state_d;
    logic                      inflight_we_q, inflight_we_d;
    logic                      resp_valid_q, resp_valid_d;
    logic                      resp_we_q, resp_we_d;
    logic [AXI_DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                      rsp_done;

    assign req_in = '{
        we:       req_we,
        uncached: req_uncached,
        addr:     req_addr,
        size:     req_size,
        wdata:    req_wdata,
        wstrb:    req_wstrb
    };

    dcache_axi_req_queue_sync_fifo #(
        .WIDTH (ReqW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (req_valid),
        .wdata_i (req_in),
        .pop_i   (fifo_pop),
        .head_o  (head_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head = dcache_mem_req_t'(head_bits);

    // Only the pulse matching the in-flight direction completes it; the other is ignored.
    assign rsp_done = (state_q == StWait) && (inflight_we_q ? mst_wvalid : mst_rvalid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (!fifo_empty && mst_ready) state_d = StWait;
            StWait: if (rsp_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mst_new_request = (state_q == StIdle) && !fifo_empty && mst_ready;
        fifo_pop        = mst_new_request;
        mst_we          = head.we;
        mst_uncached    = head.uncached;
        mst_addr        = head.addr;
        mst_size        = head.size;
        mst_data_in     = head.wdata;
        mst_wstrb       = head.wstrb;
    end

    always_comb begin
        inflight_we_d = inflight_we_q;
        resp_valid_d  = rsp_done;
        resp_we_d     = resp_we_q;
        resp_data_d   = resp_data_q;
        if (mst_new_request) begin
            inflight_we_d = head.we;
        end
        if (rsp_done) begin
            resp_we_d   = inflight_we_q;
            resp_data_d = inflight_we_q ? '0 : mst_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_we_q <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_we_q     <= 1'b0;
            resp_data_q   <= '0;
        end else begin
            inflight_we_q <= inflight_we_d;
            resp_valid_q  <= resp_valid_d;
            resp_we_q     <= resp_we_d;
            resp_data_q   <= resp_data_d;
        end
    end

    assign req_ready  = ~fifo_full;
    assign busy       = ~fifo_empty | (state_q == StWait);
    assign resp_valid = resp_valid_q;
    assign resp_we    = resp_we_q;
    assign resp_data  = resp_data_q;

endmodule
